// File: rtl/pi_lock_sequencer.sv
// rtl/pi_lock_sequencer.sv - lock-acquisition sequencer for one PI control loop
module pi_lock_sequencer #(
    parameter logic [15:0]        g_goal         = 16'd32768,
    parameter logic signed [15:0] g_acq_kp       = 16'sd8000,
    parameter logic signed [15:0] g_acq_ki       = 16'sd400,
    parameter logic signed [15:0] g_trk_kp       = 16'sd2000,
    parameter logic signed [15:0] g_trk_ki       = 16'sd50,
    parameter int unsigned        g_lock_window  = 256,
    parameter int unsigned        g_lock_count   = 1024,
    parameter int unsigned        g_unlock_count = 16,
    parameter int unsigned        g_acq_timeout  = 65535
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        d_valid_i,
    input  logic [15:0] d_i,
    output logic        pi_d_valid_o,
    output logic [15:0] pi_d_o,
    output logic [15:0] pi_kp_o,
    output logic [15:0] pi_ki_o,
    output logic        pi_rst_n_o,
    input  logic        pi_valid_i,
    input  logic [15:0] pi_q_i,
    output logic        dac_valid_o,
    output logic [15:0] dac_o,
    output logic        locked_o,
    output logic        lock_lost_o,
    output logic        fault_o,
    output logic [1:0]  state_o
);
    localparam int WIN_W = $clog2(g_lock_count + 1);
    localparam int OUT_W = $clog2(g_unlock_count + 1);
    localparam int ACQ_W = $clog2(g_acq_timeout + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
    logic               pi_d_valid_q, pi_rst_n_q, dac_valid_q;
    logic               locked_q, lock_lost_q, fault_q;
    logic [15:0]        pi_d_q, kp_q, ki_q, dac_q;

    logic [17:0]        err;
    logic [17:0]        abs_err;
    logic               in_win;
    logic               changed;
    logic               running;

    // Error is 18 bits wide so the full unsigned sample range minus the setpoint never overflows.
    assign err     = {2'b00, d_i} - {2'b00, g_goal};
    assign abs_err = err[17] ? (~err + 18'd1) : err;
    assign in_win  = (abs_err <= 18'(g_lock_window));
    assign running = (state_q == S_ACQ) || (state_q == S_TRACK);

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        out_cnt_d = out_cnt_q;
        acq_cnt_d = acq_cnt_q;
        case (state_q)
            S_IDLE: if (enable_i) state_d = S_ACQ;
            S_ACQ: if (d_valid_i) begin
                win_cnt_d = !in_win ? '0 :
                            (&win_cnt_q) ? win_cnt_q : win_cnt_q + WIN_W'(1);
                acq_cnt_d = (&acq_cnt_q) ? acq_cnt_q : acq_cnt_q + ACQ_W'(1);
                if (win_cnt_d == WIN_W'(g_lock_count))
                    state_d = S_TRACK;
                else if (acq_cnt_d == ACQ_W'(g_acq_timeout))
                    state_d = S_FAULT;
            end
            S_TRACK: if (d_valid_i) begin
                out_cnt_d = in_win ? '0 :
                            (&out_cnt_q) ? out_cnt_q : out_cnt_q + OUT_W'(1);
                if (out_cnt_d == OUT_W'(g_unlock_count))
                    state_d = S_ACQ;
            end
            default: ;
        endcase
        if (!enable_i) state_d = S_IDLE;
        changed = (state_d != state_q);
        if (changed) begin
            win_cnt_d = '0;
            out_cnt_d = '0;
            acq_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            win_cnt_q    <= '0;
            out_cnt_q    <= '0;
            acq_cnt_q    <= '0;
            pi_d_valid_q <= 1'b0;
            pi_d_q       <= '0;
            kp_q         <= g_acq_kp;
            ki_q         <= g_acq_ki;
            pi_rst_n_q   <= 1'b0;
            dac_valid_q  <= 1'b0;
            dac_q        <= 16'h8000;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            out_cnt_q    <= out_cnt_d;
            acq_cnt_q    <= acq_cnt_d;
            pi_d_valid_q <= d_valid_i && running && !changed;
            pi_d_q       <= d_i;
            kp_q         <= (state_d == S_TRACK) ? g_trk_kp : g_acq_kp;
            ki_q         <= (state_d == S_TRACK) ? g_trk_ki : g_acq_ki;
            // One-cycle integrator clear whenever ACQ is freshly entered.
            pi_rst_n_q   <= (state_d == S_TRACK) || (state_d == S_ACQ && !changed);
            locked_q     <= (state_d == S_TRACK);
            fault_q      <= (state_d == S_FAULT);
            lock_lost_q  <= (state_q == S_TRACK) && (state_d == S_ACQ);
            if (changed && (state_d == S_IDLE || state_d == S_FAULT)) begin
                dac_q       <= 16'h8000;
                dac_valid_q <= 1'b1;
            end else if (pi_valid_i && running) begin
                dac_q       <= pi_q_i ^ 16'h8000;
                dac_valid_q <= 1'b1;
            end else begin
                dac_valid_q <= 1'b0;
            end
        end
    end

    assign pi_d_valid_o = pi_d_valid_q;
    assign pi_d_o       = pi_d_q;
    assign pi_kp_o      = kp_q;
    assign pi_ki_o      = ki_q;
    assign pi_rst_n_o   = pi_rst_n_q;
    assign dac_valid_o  = dac_valid_q;
    assign dac_o        = dac_q;
    assign locked_o     = locked_q;
    assign lock_lost_o  = lock_lost_q;
    assign fault_o      = fault_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_pi_lock_sequencer.sv
// tb/tb_pi_lock_sequencer.sv - directed self-checking bench for pi_lock_sequencer
module tb_pi_lock_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, enable, d_valid, pi_valid;
    logic [15:0] d, pi_q;
    logic        pi_d_valid, pi_rst_n, dac_valid, locked, lock_lost, fault;
    logic [15:0] pi_d, pi_kp, pi_ki, dac;
    logic [1:0]  state;
    int          checks = 0;
    int          errors = 0;

    pi_lock_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .d_valid_i(d_valid), .d_i(d),
        .pi_d_valid_o(pi_d_valid), .pi_d_o(pi_d),
        .pi_kp_o(pi_kp), .pi_ki_o(pi_ki), .pi_rst_n_o(pi_rst_n),
        .pi_valid_i(pi_valid), .pi_q_i(pi_q),
        .dac_valid_o(dac_valid), .dac_o(dac),
        .locked_o(locked), .lock_lost_o(lock_lost), .fault_o(fault),
        .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " state"},      16'(state),      16'd0);
        chk({tag, " pi_d_valid"}, 16'(pi_d_valid), 16'd0);
        chk({tag, " pi_rst_n"},   16'(pi_rst_n),   16'd0);
        chk({tag, " dac_valid"},  16'(dac_valid),  16'd0);
        chk({tag, " dac"},        dac,             16'h8000);
        chk({tag, " kp"},         pi_kp,           16'd8000);
        chk({tag, " ki"},         pi_ki,           16'd400);
        chk({tag, " locked"},     16'(locked),     16'd0);
        chk({tag, " lock_lost"},  16'(lock_lost),  16'd0);
        chk({tag, " fault"},      16'(fault),      16'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; d_valid = 1'b0; d = 16'd0;
        pi_valid = 1'b0; pi_q = 16'd0;
        step(2);
        chk_reset("reset");

        // lock acquisition with a perfect setpoint
        rst_n = 1'b1; enable = 1'b1; d_valid = 1'b1; d = 16'd32768;
        step(1);
        chk("t1 enter acq state", 16'(state), 16'd1);
        chk("t1 pi_rst_n pulse", 16'(pi_rst_n), 16'd0);
        chk("t1 entry not forwarded", 16'(pi_d_valid), 16'd0);
        step(1);
        chk("t1 pi_rst_n release", 16'(pi_rst_n), 16'd1);
        chk("t1 forward valid", 16'(pi_d_valid), 16'd1);
        chk("t1 forward data", pi_d, 16'd32768);
        step(1022);
        chk("t1 1023 samples still acq", 16'(state), 16'd1);
        step(1);
        chk("t1 track state", 16'(state), 16'd2);
        chk("t1 locked", 16'(locked), 16'd1);
        chk("t1 trk kp", pi_kp, 16'd2000);
        chk("t1 trk ki", pi_ki, 16'd50);
        chk("t1 lock sample not forwarded", 16'(pi_d_valid), 16'd0);
        step(1);
        chk("t1 forwarding in track", 16'(pi_d_valid), 16'd1);

        // loss of lock needs 16 consecutive out-of-window samples
        d = 16'd40000;
        step(15);
        chk("t2 15 out still track", 16'(state), 16'd2);
        chk("t2 forward data", pi_d, 16'd40000);
        d = 16'd32768;
        step(1);
        d = 16'd40000;
        step(15);
        chk("t2 after reset run still track", 16'(state), 16'd2);
        chk("t2 no early lock_lost", 16'(lock_lost), 16'd0);
        step(1);
        chk("t2 back to acq", 16'(state), 16'd1);
        chk("t2 lock_lost pulse", 16'(lock_lost), 16'd1);
        chk("t2 pi_rst_n pulse", 16'(pi_rst_n), 16'd0);
        chk("t2 acq kp", pi_kp, 16'd8000);
        chk("t2 unlocked", 16'(locked), 16'd0);
        step(1);
        chk("t2 lock_lost single", 16'(lock_lost), 16'd0);
        chk("t2 pi_rst_n single", 16'(pi_rst_n), 16'd1);

        // offset-binary conversion in ACQ
        pi_valid = 1'b1; pi_q = 16'h8001;
        step(1);
        chk("t4 dac neg", dac, 16'h0001);
        chk("t4 dac_valid", 16'(dac_valid), 16'd1);
        pi_q = 16'h0000;
        step(1);
        chk("t4 dac zero", dac, 16'h8000);
        pi_q = 16'h7FFF;
        step(1);
        chk("t4 dac pos", dac, 16'hFFFF);
        pi_valid = 1'b0;
        step(1);
        chk("t4 dac_valid drop", 16'(dac_valid), 16'd0);
        chk("t4 dac hold", dac, 16'hFFFF);

        // disable returns to idle with a midscale DAC pulse
        enable = 1'b0;
        step(1);
        chk("t5 idle", 16'(state), 16'd0);
        chk("t5 idle dac", dac, 16'h8000);
        chk("t5 idle dac_valid", 16'(dac_valid), 16'd1);
        chk("t5 idle pi_rst_n", 16'(pi_rst_n), 16'd0);
        step(1);
        chk("t5 idle dac_valid single", 16'(dac_valid), 16'd0);

        // disable wins over the lock-reaching sample
        enable = 1'b1; d = 16'd32768;
        step(1);
        step(1023);
        chk("t5 pre-lock acq", 16'(state), 16'd1);
        enable = 1'b0;
        step(1);
        chk("t5 disable beats lock", 16'(state), 16'd0);
        chk("t5 never locked", 16'(locked), 16'd0);
        step(1);
        chk("t5 stays idle", 16'(state), 16'd0);

        // window edges: +/-256 inside, +/-257 outside
        enable = 1'b1; d = 16'd33024;
        step(1);
        step(500);
        d = 16'd33025;
        step(1);
        d = 16'd33024;
        step(523);
        chk("t6 +257 breaks run", 16'(state), 16'd1);
        d = 16'd32511;
        step(1);
        d = 16'd32512;
        step(1023);
        chk("t6 -257 breaks run", 16'(state), 16'd1);
        step(1);
        chk("t6 edges lock", 16'(state), 16'd2);

        // synchronous reset mid-track
        rst_n = 1'b0;
        step(1);
        chk_reset("t5 mid-track reset");

        // acquisition timeout
        rst_n = 1'b1; enable = 1'b1; d = 16'd0;
        step(1);
        step(65534);
        chk("t3 pre-timeout acq", 16'(state), 16'd1);
        step(1);
        chk("t3 fault state", 16'(state), 16'd3);
        chk("t3 fault_o", 16'(fault), 16'd1);
        chk("t3 fault dac", dac, 16'h8000);
        chk("t3 fault dac_valid", 16'(dac_valid), 16'd1);
        chk("t3 fault pi_rst_n", 16'(pi_rst_n), 16'd0);
        chk("t3 fault no forward", 16'(pi_d_valid), 16'd0);
        pi_valid = 1'b1; pi_q = 16'h1234;
        step(1);
        chk("t3 pi_valid ignored dac", dac, 16'h8000);
        chk("t3 pi_valid ignored strobe", 16'(dac_valid), 16'd0);
        chk("t3 fault holds", 16'(state), 16'd3);
        pi_valid = 1'b0; enable = 1'b0;
        step(1);
        chk("t3 fault to idle", 16'(state), 16'd0);
        chk("t3 fault cleared", 16'(fault), 16'd0);
        chk("t3 idle entry dac_valid", 16'(dac_valid), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
